// File: rtl/stream_loader.sv
// stream_loader: loads one frame from a valid/ready stream into a BRAM write port,
// zero-pads short frames, drops overlong tails, then runs the kernel via ap_ctrl_hs.
//
// state | meaning
// FILL  | accept stream beats, write each at idx
// PAD   | write zeros until address DEPTH-1 is written
// DROP  | swallow overlong beats up to and including tlast
// KICK  | hold k_ap_start until k_ap_ready is sampled
// WAIT  | wait for k_ap_done
module stream_loader #(
    parameter int ADDR_BITS = 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [31:0]          s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [ADDR_BITS-1:0] buf_address0,
    output logic                 buf_ce0,
    output logic                 buf_we0,
    output logic [31:0]          buf_d0,
    output logic                 k_ap_start,
    input  logic                 k_ap_ready,
    input  logic                 k_ap_done,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frame_cnt,
    output logic                 err_short,
    output logic                 err_long
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] LAST_IDX = (ADDR_BITS + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_FILL,
        ST_PAD,
        ST_DROP,
        ST_KICK,
        ST_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS:0]     idx_q, idx_d;
    logic                   tready_q, tready_d;
    logic                   wr_q, wr_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic                   done_q, done_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   short_q, short_d;
    logic                   long_q, long_d;
    logic                   set_short, set_long, complete;
    logic                   accept, start;

    assign accept = s_tvalid && tready_q;
    // The last data/pad write is still on the port in the first KICK cycle;
    // start is held back until the port is idle so the two never overlap.
    assign start  = (state_q == ST_KICK) && !wr_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        set_short = 1'b0;
        set_long  = 1'b0;
        complete  = 1'b0;

        unique case (state_q)
            ST_FILL: begin
                if (accept) begin
                    wr_d   = 1'b1;
                    addr_d = idx_q[ADDR_BITS-1:0];
                    data_d = s_tdata;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        if (s_tlast) begin
                            state_d = ST_KICK;
                        end else begin
                            state_d  = ST_DROP;
                            set_long = 1'b1;
                        end
                    end else if (s_tlast) begin
                        state_d   = ST_PAD;
                        set_short = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                wr_d   = 1'b1;
                addr_d = idx_q[ADDR_BITS-1:0];
                data_d = 32'h0;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_KICK;
                end
            end
            ST_DROP: begin
                if (accept && s_tlast) begin
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                if (start && k_ap_ready) begin
                    if (k_ap_done) begin
                        state_d  = ST_FILL;
                        complete = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (k_ap_done) begin
                    state_d  = ST_FILL;
                    complete = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase

        if (complete) begin
            idx_d = '0;
        end
        tready_d = (state_d == ST_FILL) || (state_d == ST_DROP);
        done_d   = complete;
        cnt_d    = complete ? cnt_q + 16'd1 : cnt_q;
        // A flag being set in the same cycle as err_clr stays set.
        short_d  = set_short || (short_q && !err_clr);
        long_d   = set_long || (long_q && !err_clr);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= ST_FILL;
            idx_q    <= '0;
            tready_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= 32'h0;
            done_q   <= 1'b0;
            cnt_q    <= 16'h0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tready_q <= tready_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
        end
    end

    assign s_tready     = tready_q;
    assign buf_address0 = addr_q;
    assign buf_ce0      = wr_q;
    assign buf_we0      = wr_q;
    assign buf_d0       = data_q;
    assign k_ap_start   = start;
    assign busy         = (state_q != ST_FILL);
    assign frame_done   = done_q;
    assign frame_cnt    = cnt_q;
    assign err_short    = short_q;
    assign err_long     = long_q;

endmodule

// File: tb/tb_stream_loader.sv
// Bench for stream_loader: table-driven frames, reset corner cases, then random frames
// checked against a frame-level model of the expected buffer image, flags and counts.
module tb_stream_loader;
    localparam int AB    = 2;
    localparam int DEPTH = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [31:0]   s_tdata = 32'h0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [AB-1:0] buf_address0;
    logic          buf_ce0;
    logic          buf_we0;
    logic [31:0]   buf_d0;
    logic          k_ap_start;
    logic          k_ap_ready = 1'b0;
    logic          k_ap_done = 1'b0;
    logic          err_clr = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic          err_short;
    logic          err_long;

    stream_loader #(.ADDR_BITS(AB)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .buf_address0(buf_address0), .buf_ce0(buf_ce0), .buf_we0(buf_we0), .buf_d0(buf_d0),
        .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready), .k_ap_done(k_ap_done),
        .err_clr(err_clr), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .err_short(err_short), .err_long(err_long)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // Passive monitor: records every buffer write and start rise with its cycle.
    logic [AB-1:0] w_addr[$];
    logic [31:0]   w_data[$];
    int            w_cyc[$];
    int            st_cyc[$];
    logic          start_prev = 1'b0;
    int            overlap = 0;
    int            cewe_bad = 0;
    int            done_pulses = 0;

    always @(negedge ap_clk) begin
        if (buf_ce0 !== buf_we0) cewe_bad++;
        if (buf_we0) begin
            w_addr.push_back(buf_address0);
            w_data.push_back(buf_d0);
            w_cyc.push_back(cyc);
        end
        if (k_ap_start && !start_prev) st_cyc.push_back(cyc);
        start_prev = k_ap_start;
        if (k_ap_start && buf_we0) overlap++;
        if (frame_done) done_pulses++;
    end

    int mb_w, mb_s, mb_o, mb_c, mb_d;
    logic [31:0] beats[8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mark();
        mb_w = w_data.size();
        mb_s = st_cyc.size();
        mb_o = overlap;
        mb_c = cewe_bad;
        mb_d = done_pulses;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tready"}, s_tready, 0);
        chk({tag, "_addr"}, buf_address0, 0);
        chk({tag, "_ce"}, buf_ce0, 0);
        chk({tag, "_we"}, buf_we0, 0);
        chk({tag, "_d"}, buf_d0, 0);
        chk({tag, "_start"}, k_ap_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_cnt"}, frame_cnt, 0);
        chk({tag, "_eshort"}, err_short, 0);
        chk({tag, "_elong"}, err_long, 0);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge ap_clk);
        err_clr = 1'b0;
        chk("clr_short", err_short, 0);
        chk("clr_long", err_long, 0);
    endtask

    task automatic drive_frame(input int n, input bit gaps, input bit clr_last);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge ap_clk);
            end
            s_tvalid = 1'b1;
            s_tdata  = beats[i];
            s_tlast  = (i == n - 1);
            err_clr  = clr_last && (i == n - 1);
            t = 0;
            while (!s_tready && t < 100) begin
                @(negedge ap_clk);
                t++;
            end
            if (t >= 100) chk("accept_timeout", s_tready, 1);
            @(negedge ap_clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        err_clr  = 1'b0;
    endtask

    // Kernel side of ap_ctrl_hs; optional stream noise must be ignored while busy.
    task automatic kernel(input int rdly, input int ddly, input bit spur, input bit noise);
        int t = 0;
        if (noise) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hDEADBEEF;
            s_tlast  = 1'b1;
        end
        while (!k_ap_start && t < 100) begin
            @(negedge ap_clk);
            t++;
        end
        chk("start_seen", k_ap_start, 1);
        for (int c = 0; c < rdly; c++) begin
            chk("start_hold", k_ap_start, 1);
            chk("tready_kick", s_tready, 0);
            k_ap_done = spur && (c == 0);
            @(negedge ap_clk);
        end
        chk("start_at_ready", k_ap_start, 1);
        k_ap_ready = 1'b1;
        k_ap_done  = (ddly == 0);
        @(negedge ap_clk);
        k_ap_ready = 1'b0;
        k_ap_done  = 1'b0;
        if (ddly > 0) begin
            chk("start_low_wait", k_ap_start, 0);
            chk("busy_wait", busy, 1);
            chk("tready_wait", s_tready, 0);
            repeat (ddly - 1) @(negedge ap_clk);
            k_ap_done = 1'b1;
            @(negedge ap_clk);
            k_ap_done = 1'b0;
        end
        chk("done_lat", frame_done, 1);
        chk("tready_after_done", s_tready, 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic check_frame(input int n, input bit gaps, input bit es, input bit el,
                               input int ecnt);
        int nw;
        logic [31:0] ed;
        @(negedge ap_clk);
        nw = w_data.size() - mb_w;
        chk("nwrites", nw, DEPTH);
        for (int i = 0; i < DEPTH && i < nw; i++) begin
            ed = (i < n) ? beats[i] : 32'h0;
            chk("waddr", w_addr[mb_w + i], i);
            chk("wdata", w_data[mb_w + i], ed);
            if (i > 0 && (i >= n || !gaps))
                chk("w_b2b", w_cyc[mb_w + i] - w_cyc[mb_w + i - 1], 1);
        end
        chk("nstarts", st_cyc.size() - mb_s, 1);
        if (nw == DEPTH && st_cyc.size() > mb_s) begin
            if (n <= DEPTH)
                chk("start_lat", st_cyc[mb_s] - w_cyc[mb_w + DEPTH - 1], 1);
            else if (!gaps)
                chk("start_lat_drop", st_cyc[mb_s] - w_cyc[mb_w + DEPTH - 1], n - DEPTH);
        end
        chk("overlap", overlap - mb_o, 0);
        chk("ce_we", cewe_bad - mb_c, 0);
        chk("done_pulses", done_pulses - mb_d, 1);
        chk("frame_cnt", frame_cnt, ecnt);
        chk("err_short", err_short, es);
        chk("err_long", err_long, el);
        chk("busy_idle", busy, 0);
        chk("tready_idle", s_tready, 1);
    endtask

    typedef struct {
        int          n;
        logic [31:0] base;
        logic [31:0] step;
        int          rdly;
        int          ddly;
        bit          clr;
        bit          es;
        bit          el;
        int          cnt;
    } vec_t;

    vec_t tbl[8];
    int   model_cnt;
    bit   exp_s, exp_l;
    int   n;
    bit   gaps, clr;

    initial begin
        tbl[0] = '{4, 32'h11, 32'h11, 2, 3, 0, 0, 0, 1};
        tbl[1] = '{2, 32'hA, 32'h1, 1, 2, 0, 1, 0, 2};
        tbl[2] = '{6, 32'h100, 32'h1, 0, 1, 0, 0, 1, 3};
        tbl[3] = '{4, 32'h200, 32'h1, 0, 0, 0, 0, 0, 4};
        tbl[4] = '{3, 32'h300, 32'h1, 5, 2, 1, 1, 0, 5};
        tbl[5] = '{1, 32'hFFFFFFF0, 32'h1, 1, 0, 0, 1, 0, 6};
        tbl[6] = '{7, 32'hC0DE0000, 32'h3, 3, 1, 1, 0, 0, 7};
        tbl[7] = '{5, 32'h500, 32'h1, 0, 4, 0, 0, 1, 8};

        repeat (3) @(negedge ap_clk);
        check_reset("por");
        ap_rst = 1'b0;
        @(negedge ap_clk);

        for (int v = 0; v < 8; v++) begin
            clear_err();
            for (int i = 0; i < tbl[v].n; i++)
                beats[i] = tbl[v].base + tbl[v].step * 32'(i);
            mark();
            drive_frame(tbl[v].n, 1'b0, tbl[v].clr);
            kernel(tbl[v].rdly, tbl[v].ddly, 1'b1, 1'b1);
            check_frame(tbl[v].n, 1'b0, tbl[v].es, tbl[v].el, tbl[v].cnt);
        end

        // Reset two beats into a frame, with err_long and frame_cnt nonzero.
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tdata  = 32'h5A5A0001;
        @(negedge ap_clk);
        s_tdata  = 32'h5A5A0002;
        @(negedge ap_clk);
        s_tvalid = 1'b0;
        ap_rst   = 1'b1;
        @(negedge ap_clk);
        check_reset("rst_mid");
        ap_rst = 1'b0;
        @(negedge ap_clk);
        for (int i = 0; i < DEPTH; i++) beats[i] = 32'h7000 + 32'(i);
        mark();
        drive_frame(DEPTH, 1'b0, 1'b0);
        kernel(0, 1, 1'b0, 1'b0);
        check_frame(DEPTH, 1'b0, 1'b0, 1'b0, 1);

        model_cnt = 1;
        exp_s = 1'b0;
        exp_l = 1'b0;
        for (int f = 0; f < 25; f++) begin
            n    = $urandom_range(1, 7);
            gaps = $urandom_range(0, 1) == 1;
            clr  = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 2) == 0) begin
                clear_err();
                exp_s = 1'b0;
                exp_l = 1'b0;
            end
            for (int i = 0; i < n; i++) beats[i] = $urandom;
            mark();
            drive_frame(n, gaps, clr);
            kernel($urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            // Overlong is flagged at beat DEPTH, before tlast; short is flagged at tlast.
            if (n > DEPTH) exp_l = 1'b1;
            if (clr) begin
                exp_s = 1'b0;
                exp_l = 1'b0;
            end
            if (n < DEPTH) exp_s = 1'b1;
            model_cnt = (model_cnt + 1) & 16'hFFFF;
            check_frame(n, gaps, exp_s, exp_l, model_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_loader.md
# stream_loader

Upstream feeder for the HLS kernel wrapper. Accepts one frame of 32-bit words on a valid/ready stream and writes it into the kernel's input buffer through a BRAM-style write port, zero-padding short frames and discarding overlong ones. After the buffer is filled, it starts the kernel with an ap_ctrl_hs handshake and waits for ap_done. It then re-arms for the next frame.

## Interface
- ADDR_BITS, 2, buffer address width; DEPTH = 2**ADDR_BITS words per frame
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  reset, synchronous, active-high
- s_tdata  in  32  stream word
- s_tvalid  in  1  stream word valid
- s_tlast  in  1  marks final word of frame
- s_tready  out  1  stream ready; reset 0
- buf_address0  out  ADDR_BITS  buffer write address; reset 0
- buf_ce0  out  1  buffer chip enable; reset 0
- buf_we0  out  1  buffer write enable; reset 0
- buf_d0  out  32  buffer write data; reset 0
- k_ap_start  out  1  kernel start; reset 0
- k_ap_ready  in  1  kernel accepted start
- k_ap_done  in  1  kernel finished
- err_clr  in  1  clears sticky error flags
- busy  out  1  high in any state except FILL; reset 0
- frame_done  out  1  one-cycle pulse per completed kernel run; reset 0
- frame_cnt  out  16  completed runs, wraps 0xFFFF->0; reset 0
- err_short  out  1  sticky: frame had tlast before DEPTH words; reset 0
- err_long  out  1  sticky: frame exceeded DEPTH words; reset 0

## Operation
- Internal word index idx (ADDR_BITS+1 bits), reset 0.
- States: FILL (reset state), PAD, DROP, KICK, WAIT.
- FILL: s_tready=1. Each beat is accepted when s_tvalid&s_tready at a rising edge.
  - Each accepted beat writes s_tdata at address idx, then idx++.
  - Accepted beat with s_tlast and idx==DEPTH-1 -> KICK.
  - Accepted beat with s_tlast and idx<DEPTH-1 -> PAD; set err_short.
  - Accepted beat without s_tlast and idx==DEPTH-1 -> DROP; set err_long.
- PAD: s_tready=0. Writes 0 at idx, one word per cycle, until address DEPTH-1 is written, then -> KICK.
- DROP: s_tready=1. Accepted beats are discarded with no buffer write. The beat with s_tlast is accepted and discarded, then -> KICK.
- KICK: s_tready=0; k_ap_start=1, held until k_ap_ready=1 is sampled.
  - k_ap_ready without k_ap_done -> WAIT.
  - k_ap_ready with k_ap_done in the same cycle -> FILL directly, with frame completion.
  - k_ap_done without k_ap_ready is ignored.
- WAIT: s_tready=0, k_ap_start=0. When k_ap_done=1 -> FILL with frame completion.
- Frame completion: frame_done pulses, frame_cnt increments, idx resets to 0.
- Error flags: err_short/err_long stay set until err_clr. If err_clr and a new error set occur in the same cycle, set wins.
- Synchronous reset at any point (mid-fill, mid-kick) discards the frame. All outputs take their reset values on that edge; the state returns to FILL.

## Timing
- Buffer write latency: a beat accepted at edge T appears as buf_ce0=buf_we0=1 with address/data registered in cycle T+1, one cycle wide. buf_ce0=buf_we0=0 otherwise. buf_address0 and buf_d0 hold their last value when idle.
- Full-length frame: DEPTH back-to-back beats give DEPTH consecutive write cycles. k_ap_start rises the cycle after the final write cycle, never overlapping a write.
- PAD writes are back-to-back with the preceding data write, with no bubble.
- frame_done is asserted in the cycle after the edge where k_ap_done is sampled. s_tready returns to 1 in that same cycle.
- Throughput: one beat per cycle while in FILL.

## Test plan
- ADDR_BITS=2, beats 0x11,0x22,0x33,0x44(tlast) back-to-back -> writes addr0..3 with those values on consecutive cycles. k_ap_start rises the next cycle and holds until k_ap_ready. After k_ap_done: frame_done pulses once, frame_cnt=1, errors 0.
- Short frame 0xA,0xB(tlast) -> writes addr0=0xA, addr1=0xB, addr2=0, addr3=0 back-to-back; err_short=1; s_tready=0 during pad.
- Long frame of 6 beats, tlast on the 6th -> only the first 4 beats are written. Beats 5-6 are accepted with no writes. err_long=1; kernel is started once.
- Kernel asserts k_ap_ready and k_ap_done in the same cycle as the first k_ap_start -> state goes directly to FILL, frame_done pulses once, WAIT is never entered.
- Kernel delays k_ap_ready 5 cycles -> k_ap_start stays 1 for all 5 cycles and s_tvalid is ignored. Assert err_clr while an error is being set -> flag remains 1.
- ap_rst asserted after 2 beats of a frame -> all outputs return to reset values on the next edge. A following full frame writes from addr0, and frame_cnt counts from 0.
